lockin_photon_counter: RTL and testbench
========================================

Name: lockin_photon_counter

Overview:
- Multi-channel, parametrised successor to the modulated-source PMT counter.
- Drives the light-source modulation pin and counts synchronised PMT pulse edges per channel into light-on (add) and light-off (subtract) bins.
- Discards pulses inside a blanking window after each light transition.
- At each integration-window end, publishes per-channel add/subtract counts and a signed difference through a valid/ready result interface.

Parameters:
- NUM_CH, 2: number of independent PMT input channels.
- CNT_W, 32: width of each add/subtract counter.
- MOD_HALF_PERIOD, 500000: clock cycles per light-on or light-off half period; minimum 4.
- INT_PERIODS, 500: full modulation periods (on plus off) per integration window; minimum 1.
- BLANK_CYCLES, 16: cycles after every light toggle during which detected pulses are discarded; must be less than MOD_HALF_PERIOD.
- SYNC_STAGES, 2: synchroniser flops per PMT input; minimum 2.

Ports:
- clock_50_mhz  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- pmt_in  input  NUM_CH  raw asynchronous PMT pulse inputs
- enable  input  1  run/stop
- light_source_pin  output  1  modulation drive, 1 = light on
- result_valid  output  1  result registers hold an unconsumed window
- result_ready  input  1  consumer accepts the result
- add_count  output  NUM_CH*CNT_W  light-on counts, channel 0 in the LSBs
- subtract_count  output  NUM_CH*CNT_W  light-off counts
- signed_diff  output  NUM_CH*(CNT_W+1)  add minus subtract, two's complement
- overflow  output  NUM_CH  a counter saturated during the window
- overrun  output  1  one-cycle pulse: an unconsumed result was overwritten
- frame_count  output  16  completed windows since reset, wraps at 65535

Behaviour:
- Reset (asynchronous, reset_n low):
  - All outputs are 0.
  - State is IDLE.
  - Timers, internal counters and synchroniser flops are cleared.
- States:
  - IDLE: light_source_pin is 0; timers and counters are held at 0. Transition IDLE to RUN on the first cycle enable is 1.
  - RUN: the first cycle is phase timer 0 with light_source_pin 1.
- Phase timer:
  - Counts 0 to MOD_HALF_PERIOD-1.
  - On the cycle after it reaches MOD_HALF_PERIOD-1, the timer wraps to 0 and light_source_pin toggles.
  - The period counter increments on each off-to-on toggle.
- Pulse detection:
  - Each pmt_in bit passes through SYNC_STAGES flops, then a rising-edge detector.
  - Detection latency is SYNC_STAGES+1 cycles.
  - Inputs must be at least 1 clock high and 1 clock low; narrower pulses may be missed.
- Pulse binning:
  - A detected edge is binned by light_source_pin on the detection cycle: 1 goes to add, 0 goes to subtract.
  - If the phase timer is below BLANK_CYCLES, the edge is dropped and goes in neither bin.
  - Channels are fully independent; simultaneous edges on several channels are all counted.
- Saturation:
  - Counters saturate at 2^CNT_W-1.
  - An increment attempted at saturation sets that channel's window overflow bit.
- Window end:
  - The window ends on the last cycle of period INT_PERIODS (light off, timer MOD_HALF_PERIOD-1).
  - An edge detected on that cycle is included in the closing window.
  - On the next cycle:
    - add_count, subtract_count, signed_diff and overflow are loaded.
    - signed_diff is add_count minus subtract_count, both zero-extended to CNT_W+1.
    - result_valid is set to 1 and frame_count increments.
    - Internal counters, overflow bits and the period counter restart at 0 with no dead cycle.
- Handshake:
  - A result is consumed on a cycle with result_valid and result_ready both 1; result_valid clears the next cycle.
  - Output registers hold their values until the next window end.
  - If result_valid is still 1 at a window end and no handshake occurs that cycle:
    - new values overwrite the old ones;
    - result_valid stays 1;
    - overrun pulses for 1 cycle.
  - A handshake on the same cycle as a load is not an overrun, and the new result is valid.
- enable falls in RUN:
  - The next cycle returns to IDLE and light_source_pin goes to 0.
  - The partial window is discarded.
  - Published results, result_valid and frame_count are retained.
- reset_n asserted mid-window discards everything, per the reset rule above.

Test Plan:
- Bench parameters: NUM_CH=2, CNT_W=4, MOD_HALF_PERIOD=10, INT_PERIODS=2, BLANK_CYCLES=2.
- Reset: reset_n low with pmt_in toggling -> every output is 0 and light_source_pin stays 0 while enable is 0.
- Basic count: enable=1; channel 0 gets 3 edges detected in on-phases at timer 5 and 1 edge in an off-phase at timer 6 -> 40 cycles after RUN entry, result_valid=1, ch0 add=3, sub=1, diff=+2, frame_count=1.
- Negative difference and blanking:
  - Channel 1 gets 1 on-edge and 4 off-edges, plus 2 edges detected at timer 0 and 1 -> ch1 add=1, sub=4, diff=-3, i.e. 5'b11101.
  - The two blanked edges are counted nowhere.
- Saturation: 20 on-edges on channel 0 in one window -> add=15, overflow[0]=1, overflow[1]=0; the next window restarts from 0.
- Overrun: hold result_ready at 0 across two window ends -> overrun pulses once; outputs show second-window values; a single ready cycle clears result_valid.
- Abort: drop enable at cycle 25 of a window -> IDLE, light pin 0, no new result; re-enable -> a full 40-cycle window produces correct counts.

Source files
------------

// File: rtl/lockin_photon_counter.sv
// Lock-in photon counter: drives the light-source modulation and bins PMT pulse
// edges per channel into light-on (add) and light-off (subtract) counts per window.
module lockin_photon_counter #(
  parameter int NUM_CH          = 2,
  parameter int CNT_W           = 32,
  parameter int MOD_HALF_PERIOD = 500000,
  parameter int INT_PERIODS     = 500,
  parameter int BLANK_CYCLES    = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                        clock_50_mhz,
  input  logic                        reset_n,
  input  logic [NUM_CH-1:0]           pmt_in,
  input  logic                        enable,
  output logic                        light_source_pin,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [NUM_CH*CNT_W-1:0]     add_count,
  output logic [NUM_CH*CNT_W-1:0]     subtract_count,
  output logic [NUM_CH*(CNT_W+1)-1:0] signed_diff,
  output logic [NUM_CH-1:0]           overflow,
  output logic                        overrun,
  output logic [15:0]                 frame_count
);

  localparam int TIMER_W  = $clog2(MOD_HALF_PERIOD);
  localparam int PERIOD_W = (INT_PERIODS > 1) ? $clog2(INT_PERIODS) : 1;

  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(MOD_HALF_PERIOD - 1);
  localparam logic [TIMER_W-1:0]  BLANK_END   = TIMER_W'(BLANK_CYCLES);
  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(INT_PERIODS - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t              state_reg;
  logic [TIMER_W-1:0]  timer_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic                light_reg;
  logic                valid_reg;
  logic                overrun_reg;
  logic [15:0]         frame_reg;

  logic running;
  logic window_end;
  logic blanked;

  // Dropping enable takes effect on the same cycle, so a window that ends while
  // enable is low is discarded together with the partial counts.
  assign running    = (state_reg == RUN) && enable;
  assign window_end = running && !light_reg && (timer_reg == TIMER_LAST) &&
                      (period_reg == PERIOD_LAST);
  assign blanked    = (timer_reg < BLANK_END);

  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      period_reg  <= '0;
      light_reg   <= 1'b0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      frame_reg   <= '0;
    end else begin
      overrun_reg <= 1'b0;
      if (valid_reg && result_ready) begin
        valid_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          timer_reg  <= '0;
          period_reg <= '0;
          light_reg  <= 1'b0;
          if (enable) begin
            state_reg <= RUN;
            light_reg <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            state_reg  <= IDLE;
            timer_reg  <= '0;
            period_reg <= '0;
            light_reg  <= 1'b0;
          end else begin
            if (timer_reg == TIMER_LAST) begin
              timer_reg <= '0;
              light_reg <= ~light_reg;
              if (!light_reg) begin
                period_reg <= window_end ? '0 : period_reg + PERIOD_W'(1);
              end
            end else begin
              timer_reg <= timer_reg + TIMER_W'(1);
            end
            if (window_end) begin
              // A same-cycle handshake consumes the old result, so no overrun.
              valid_reg   <= 1'b1;
              overrun_reg <= valid_reg && !result_ready;
              frame_reg   <= frame_reg + 16'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign light_source_pin = light_reg;
  assign result_valid     = valid_reg;
  assign overrun          = overrun_reg;
  assign frame_count      = frame_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   edge_reg;
    logic [CNT_W-1:0]       add_reg;
    logic [CNT_W-1:0]       add_next;
    logic [CNT_W-1:0]       sub_reg;
    logic [CNT_W-1:0]       sub_next;
    logic                   ovf_reg;
    logic                   ovf_next;
    logic [CNT_W-1:0]       add_out_reg;
    logic [CNT_W-1:0]       sub_out_reg;
    logic [CNT_W:0]         diff_out_reg;
    logic                   ovf_out_reg;

    always_ff @(posedge clock_50_mhz or negedge reset_n) begin
      if (!reset_n) begin
        sync_reg <= '0;
        prev_reg <= 1'b0;
        edge_reg <= 1'b0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], pmt_in[gi]};
        prev_reg <= sync_reg[SYNC_STAGES-1];
        edge_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
      end
    end

    always_comb begin
      add_next = add_reg;
      sub_next = sub_reg;
      ovf_next = ovf_reg;
      if (running && edge_reg && !blanked) begin
        if (light_reg) begin
          if (add_reg == CNT_MAX) begin
            ovf_next = 1'b1;
          end else begin
            add_next = add_reg + CNT_W'(1);
          end
        end else begin
          if (sub_reg == CNT_MAX) begin
            ovf_next = 1'b1;
          end else begin
            sub_next = sub_reg + CNT_W'(1);
          end
        end
      end
    end

    always_ff @(posedge clock_50_mhz or negedge reset_n) begin
      if (!reset_n) begin
        add_reg <= '0;
        sub_reg <= '0;
        ovf_reg <= 1'b0;
      end else if (!running || window_end) begin
        add_reg <= '0;
        sub_reg <= '0;
        ovf_reg <= 1'b0;
      end else begin
        add_reg <= add_next;
        sub_reg <= sub_next;
        ovf_reg <= ovf_next;
      end
    end

    // Publishing the _next values keeps an edge on the closing cycle in this window.
    always_ff @(posedge clock_50_mhz or negedge reset_n) begin
      if (!reset_n) begin
        add_out_reg  <= '0;
        sub_out_reg  <= '0;
        diff_out_reg <= '0;
        ovf_out_reg  <= 1'b0;
      end else if (window_end) begin
        add_out_reg  <= add_next;
        sub_out_reg  <= sub_next;
        diff_out_reg <= {1'b0, add_next} - {1'b0, sub_next};
        ovf_out_reg  <= ovf_next;
      end
    end

    assign add_count[gi*CNT_W +: CNT_W]           = add_out_reg;
    assign subtract_count[gi*CNT_W +: CNT_W]      = sub_out_reg;
    assign signed_diff[gi*(CNT_W+1) +: (CNT_W+1)] = diff_out_reg;
    assign overflow[gi]                           = ovf_out_reg;
  end

endmodule

// File: tb/tb_lockin_photon_counter.sv
// Bench for lockin_photon_counter: table of windows with a result scoreboard,
// plus hand-written overrun, abort, saturation and reset sequences.
module tb_lockin_photon_counter;

  localparam int NC = 2;
  localparam int CW = 4;
  localparam int HP = 10;
  localparam int IP = 2;
  localparam int BL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, en, rdy;
  logic [NC-1:0]        pmt;
  logic                 light, valid, ovr;
  logic [NC*CW-1:0]     addc, subc;
  logic [NC*(CW+1)-1:0] diffc;
  logic [NC-1:0]        ovf;
  logic [15:0]          frame;

  logic                 s_en, s_rdy;
  logic [NC-1:0]        s_pmt;
  logic                 s_light, s_valid, s_ovr;
  logic [NC*CW-1:0]     s_add, s_sub;
  logic [NC*(CW+1)-1:0] s_diff;
  logic [NC-1:0]        s_ovf;
  logic [15:0]          s_frame;

  lockin_photon_counter #(
    .NUM_CH(NC), .CNT_W(CW), .MOD_HALF_PERIOD(HP), .INT_PERIODS(IP),
    .BLANK_CYCLES(BL), .SYNC_STAGES(2)
  ) dut (
    .clock_50_mhz(clk), .reset_n(rst_n), .pmt_in(pmt), .enable(en),
    .light_source_pin(light), .result_valid(valid), .result_ready(rdy),
    .add_count(addc), .subtract_count(subc), .signed_diff(diffc),
    .overflow(ovf), .overrun(ovr), .frame_count(frame)
  );

  // Longer on-phase so twenty separable edges fit into one window.
  lockin_photon_counter #(
    .NUM_CH(NC), .CNT_W(CW), .MOD_HALF_PERIOD(48), .INT_PERIODS(1),
    .BLANK_CYCLES(BL), .SYNC_STAGES(2)
  ) sat_dut (
    .clock_50_mhz(clk), .reset_n(rst_n), .pmt_in(s_pmt), .enable(s_en),
    .light_source_pin(s_light), .result_valid(s_valid), .result_ready(s_rdy),
    .add_count(s_add), .subtract_count(s_sub), .signed_diff(s_diff),
    .overflow(s_ovf), .overrun(s_ovr), .frame_count(s_frame)
  );

  typedef struct {
    logic [39:0] det0;
    logic [39:0] det1;
    logic [3:0]  a0, s0;
    logic [4:0]  d0;
    logic [3:0]  a1, s1;
    logic [4:0]  d1;
    logic [1:0]  ovf;
  } win_t;

  typedef struct {
    logic [7:0]  add;
    logic [7:0]  sub;
    logic [9:0]  diff;
    logic [1:0]  ovf;
    logic [15:0] frame;
  } exp_t;

  win_t       tbl [8];
  int         base [8] = '{0, 40, 80, 120, 160, 200, 240, 300};
  logic [1:0] det_at [0:511];
  exp_t       sb_q [$];
  int         n_cmp, n_fail, gc, ovr_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [39:0] m8(input int a, b, c, d, e, f, g, h);
    logic [39:0] r;
    int v [8];
    r = '0;
    v = '{a, b, c, d, e, f, g, h};
    foreach (v[i]) if (v[i] >= 0) r[v[i]] = 1'b1;
    return r;
  endfunction

  function automatic exp_t to_exp(input win_t w, input int fr);
    exp_t r;
    r.add   = {w.a1, w.a0};
    r.sub   = {w.s1, w.s0};
    r.diff  = {w.d1, w.d0};
    r.ovf   = w.ovf;
    r.frame = 16'(fr);
    return r;
  endfunction

  function automatic logic sdet0(input int x);
    return (x >= 2 && x <= 40 && (x % 2) == 0) || (x >= 101 && x <= 105 && (x % 2) == 1);
  endfunction

  function automatic logic sdet1(input int x);
    return (x == 10) || (x == 12);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A pulse set in cycle c is detected (and binned) in cycle c+3.
  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      pmt = det_at[gc+3];
      tick();
      gc++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (ovr === 1'b1) begin
        ovr_seen++;
        if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
      if (valid === 1'b1 && rdy === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got frame %0d, expected no result", frame);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("add_count f%0d", e.frame), 32'(addc), 32'(e.add));
          chk($sformatf("subtract_count f%0d", e.frame), 32'(subc), 32'(e.sub));
          chk($sformatf("signed_diff f%0d", e.frame), 32'(diffc), 32'(e.diff));
          chk($sformatf("overflow f%0d", e.frame), 32'(ovf), 32'(e.ovf));
          chk($sformatf("frame_count f%0d", e.frame), 32'(frame), 32'(e.frame));
        end
      end
    end
  end

  initial begin
    int sw;
    n_cmp = 0; n_fail = 0; ovr_seen = 0; gc = 0;
    rst_n = 1'b0; en = 1'b0; rdy = 1'b1; pmt = '0;
    s_en = 1'b0; s_rdy = 1'b1; s_pmt = '0;

    //              det0                                  det1                                  a0    s0    d0        a1    s1    d1        ovf
    tbl[0] = '{m8(5, 7, 25, 16, -1, -1, -1, -1),    m8(3, 12, 14, 32, 34, 10, 21, -1),    4'd3, 4'd1, 5'b00010, 4'd1, 4'd4, 5'b11101, 2'b00};
    tbl[1] = '{m8(2, 29, 39, 11, -1, -1, -1, -1),   m8(20, 30, -1, -1, -1, -1, -1, -1),   4'd2, 4'd1, 5'b00001, 4'd0, 4'd0, 5'b00000, 2'b00};
    tbl[2] = '{m8(4, 12, 14, 16, 18, -1, -1, -1),   m8(2, 4, 6, 8, 22, 24, 26, 38),       4'd1, 4'd4, 5'b11101, 4'd7, 4'd1, 5'b00110, 2'b00};
    tbl[3] = '{m8(9, 19, -1, -1, -1, -1, -1, -1),   m8(15, 17, -1, -1, -1, -1, -1, -1),   4'd1, 4'd1, 5'b00000, 4'd0, 4'd2, 5'b11110, 2'b00};
    tbl[4] = '{m8(3, -1, -1, -1, -1, -1, -1, -1),   m8(8, -1, -1, -1, -1, -1, -1, -1),    4'd1, 4'd0, 5'b00001, 4'd1, 4'd0, 5'b00001, 2'b00};
    tbl[5] = '{m8(13, 15, 17, -1, -1, -1, -1, -1),  m8(27, -1, -1, -1, -1, -1, -1, -1),   4'd0, 4'd3, 5'b11101, 4'd1, 4'd0, 5'b00001, 2'b00};
    tbl[6] = '{m8(5, 7, -1, -1, -1, -1, -1, -1),    m8(15, 30, -1, -1, -1, -1, -1, -1),   4'd0, 4'd0, 5'b00000, 4'd0, 4'd0, 5'b00000, 2'b00};
    tbl[7] = '{m8(4, 24, 13, -1, -1, -1, -1, -1),   m8(33, 35, 26, -1, -1, -1, -1, -1),   4'd2, 4'd1, 5'b00001, 4'd1, 4'd2, 5'b11111, 2'b00};

    for (int i = 0; i < 512; i++) det_at[i] = 2'b00;
    for (int w = 0; w < 8; w++)
      for (int n = 0; n < 40; n++)
        det_at[base[w] + n] = {tbl[w].det1[n], tbl[w].det0[n]};

    for (int i = 0; i < 6; i++) begin
      pmt = (i % 2 == 1) ? 2'b11 : 2'b00;
      tick();
    end
    chk("reset light", 32'(light), 0);
    chk("reset valid", 32'(valid), 0);
    chk("reset add", 32'(addc), 0);
    chk("reset sub", 32'(subc), 0);
    chk("reset diff", 32'(diffc), 0);
    chk("reset ovf/ovr", 32'({ovf, ovr}), 0);
    chk("reset frame", 32'(frame), 0);

    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pmt = (i % 2 == 0) ? 2'b11 : 2'b00;
      tick();
    end
    pmt = 2'b00;
    repeat (5) tick();
    chk("idle light", 32'(light), 0);
    chk("idle valid", 32'(valid), 0);

    en = 1'b1;
    tick();
    gc = 0;
    chk("run first light", 32'(light), 1);
    for (int w = 0; w < 4; w++) begin
      sb_q.push_back(to_exp(tbl[w], w + 1));
      advance(10);
      chk($sformatf("off phase light w%0d", w), 32'(light), 0);
      advance(30);
    end
    advance(1);

    rdy = 1'b0;
    sb_q.push_back(to_exp(tbl[4], 5));
    sb_q.push_back(to_exp(tbl[5], 6));
    advance(84);
    chk("valid held", 32'(valid), 1);
    rdy = 1'b1;
    advance(1);
    rdy = 1'b0;
    chk("valid cleared", 32'(valid), 0);
    chk("overrun pulses", 32'(ovr_seen), 1);

    advance(19);
    en = 1'b0;
    advance(1);
    chk("abort light", 32'(light), 0);
    advance(33);
    chk("abort no result", 32'(valid), 0);
    chk("abort frame", 32'(frame), 6);
    en = 1'b1;
    rdy = 1'b1;
    sb_q.push_back(to_exp(tbl[7], 7));
    advance(1);
    chk("rerun light", 32'(light), 1);
    advance(45);
    en = 1'b0;
    chk("scoreboard drained", 32'(sb_q.size()), 0);

    sw = 0;
    s_en = 1'b1;
    tick();
    for (int k = 0; k < 200; k++) begin
      s_pmt = {sdet1(k + 3), sdet0(k + 3)};
      tick();
      if (s_valid === 1'b1) begin
        if (sw == 0) begin
          chk("sat add", 32'(s_add), 32'h2F);
          chk("sat diff", 32'(s_diff), 32'({5'd2, 5'd15}));
          chk("sat overflow", 32'(s_ovf), 32'b01);
          chk("sat frame", 32'(s_frame), 1);
        end else begin
          chk("sat restart add", 32'(s_add), 32'h03);
          chk("sat restart diff", 32'(s_diff), 32'({5'd0, 5'd3}));
          chk("sat restart overflow", 32'(s_ovf), 0);
          chk("sat restart frame", 32'(s_frame), 2);
        end
        chk("sat sub/overrun", 32'({s_sub, s_ovr}), 0);
        chk("sat light", 32'(s_light), 1);
        sw++;
      end
    end
    chk("sat windows", 32'(sw), 2);

    en = 1'b1;
    repeat (15) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrun reset frame", 32'(frame), 0);
    chk("midrun reset light/valid", 32'({light, valid}), 0);
    chk("midrun reset add", 32'(addc), 0);
    chk("midrun reset diff", 32'(diffc), 0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
